cmd_arbiter: RTL and testbench
==============================

// Module: cmd_arbiter
// PURPOSE
//  Shares the single SD host CMD controller (cmd_control) between NUM_REQ command requesters (e.g. register I/F, DMA).
//  Round-robin arbitration, issues one command at a time via new_command, runs its own response-timeout counter
//  driving the controller's timeout input, returns response/status to the granted requester. Sits between requesters and cmd_control.
// PARAMETERS
//  NUM_REQ        2    number of requesters (>=2)
//  TIMEOUT_CYCLES 64   host-clock cycles in WAIT before timeout is declared (>=2)
//  CNT_W          7    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  iClock_host           in   1          host clock
//  iReset                in   1          async reset, active-high
//  iReq                  in   NUM_REQ    request level per requester; held until its oDone
//  iReq_index            in   6*NUM_REQ  cmd index, requester r at [6r+5:6r]
//  iReq_argument         in   32*NUM_REQ cmd argument, requester r at [32r+31:32r]
//  oGrant                out  NUM_REQ    one-hot, requester currently owning cmd_control
//  oDone                 out  NUM_REQ    1-cycle pulse to granted requester at end of command
//  oResponse             out  48         captured response, valid while oDone high
//  oRsp_timeout          out  1          status with oDone: command timed out
//  oRsp_index_error      out  1          status with oDone: cmd_control flagged index error
//  oNew_command          out  1          to cmd_control
//  oCmd_index            out  6          to cmd_control
//  oCmd_argument         out  32         to cmd_control
//  oTimeout_enable       out  1          to cmd_control; 1 whenever a command is in flight
//  oTimeout              out  1          to cmd_control
//  iIdle_out             in   1          from cmd_control
//  iCommand_complete     in   1          from cmd_control
//  iCommand_index_error  in   1          from cmd_control
//  iResponse             in   48         from cmd_control
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, RR pointer=0 (req0 highest priority first), counter=0.
//  IDLE: if any iReq and iIdle_out=1 -> grant winner (RR, search from pointer), latch its index/argument into
//    oCmd_index/oCmd_argument, oGrant one-hot, -> ISSUE. No request or cmd_control busy: stay.
//  ISSUE: oNew_command=1, oTimeout_enable=1; hold until iIdle_out=0 (controller accepted) -> WAIT, clear counter.
//    oNew_command deasserts the cycle WAIT is entered.
//  WAIT: counter increments per cycle. iCommand_complete=1 -> capture iResponse, iCommand_index_error -> DONE.
//    counter==TIMEOUT_CYCLES-1 without complete -> oTimeout=1 (level), -> ABORT.
//    Complete and expiry in same cycle: complete wins, no timeout.
//  ABORT: oTimeout held 1 until iIdle_out=1, then oTimeout=0, oRsp_timeout set, oResponse=0 -> DONE.
//  DONE: one cycle: oDone[granted]=1 with oResponse/status; RR pointer = granted+1 (mod NUM_REQ); clear oGrant,
//    oTimeout_enable -> IDLE. Earliest next grant is the cycle after DONE (one-cycle turnaround).
//  Latency: iReq to oNew_command = 2 cycles when idle (grant reg, then ISSUE).
//  Requester dropping iReq after grant: command still completes, oDone still pulses (ignored by requester).
//  iIdle_out falling while IDLE: no grant issued until it returns high.
//  Async reset mid-command: all state cleared immediately, no oDone; cmd_control reset by the same iReset.
//  Status flags and oResponse only meaningful when oDone pulses; held otherwise but not guaranteed.
// STRUCTURE
//  Package cmd_pkg: CMD_INDEX_W=6, CMD_ARG_W=32, CMD_RSP_W=48, FSM encodings
//    ST_IDLE/ST_ISSUE/ST_WAIT/ST_ABORT/ST_DONE (3-bit).
//  Sub-module rr_arbiter (NUM_REQ): combinational one-hot winner from req vector and pointer; pointer reg stays here.
//  Top: FSM, timeout counter, index/argument mux + capture regs, response/status capture.
// TESTING
//  1 single req0 idx=6'h11 arg=32'd5; complete after 10 cyc, iResponse=48'h123456789ABC
//    -> oNew_command 2 cyc after iReq, oDone[0] one pulse, oResponse=48'h123456789ABC, both status 0.
//  2 req0 and req1 asserted together, each held -> grants 0,1,0,1 in order; never two oGrant bits set.
//  3 no complete: TIMEOUT_CYCLES=64 -> oTimeout rises 64 cyc after WAIT entry, stays until iIdle_out=1;
//    then oDone with oRsp_timeout=1, oResponse=0.
//  4 iCommand_index_error=1 with complete (cmd_in=48'hFFFFFFFFFFFF case) -> oRsp_index_error=1 at oDone.
//  5 complete on exact expiry cycle -> oRsp_timeout=0, oTimeout never asserted.
//  6 iReset pulsed mid-WAIT -> all outputs 0 within same cycle, no oDone; next req0 served normally.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the SD CMD-path arbiter: field widths and FSM encoding.
package cmd_pkg;

    localparam int CMD_INDEX_W = 6;
    localparam int CMD_ARG_W   = 32;
    localparam int CMD_RSP_W   = 48;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ABORT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection. The winner is combinational from the request
// vector and the priority pointer. The pointer moves to one past the served
// requester when advance_i is pulsed.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    input  logic [NUM_REQ-1:0] grant_i,
    output logic [NUM_REQ-1:0] winner_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] winner_hi_s;
    logic [NUM_REQ-1:0] winner_lo_s;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        winner_hi_s = {NUM_REQ{1'b0}};
        winner_lo_s = {NUM_REQ{1'b0}};
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_i[j] && (j >= int'(ptr_q))) begin
                winner_hi_s    = {NUM_REQ{1'b0}};
                winner_hi_s[j] = 1'b1;
            end else begin
                winner_hi_s = winner_hi_s;
            end
            if (req_i[j]) begin
                winner_lo_s    = {NUM_REQ{1'b0}};
                winner_lo_s[j] = 1'b1;
            end else begin
                winner_lo_s = winner_lo_s;
            end
        end
        if (|winner_hi_s) begin
            winner_o = winner_hi_s;
        end else begin
            winner_o = winner_lo_s;
        end
    end

    // Next pointer: one past the requester just served, wrapping to zero.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (grant_i[j]) begin
                    ptr_d = (j == NUM_REQ - 1) ? {PTR_W{1'b0}} : PTR_W'(j + 1);
                end else begin
                    ptr_d = ptr_d;
                end
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register; requester 0 starts with top priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= {PTR_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Shares one SD host CMD controller between NUM_REQ requesters. Requesters are
// picked round-robin and served one command at a time. A local response
// timeout drives the controller's timeout input. The response and status are
// returned to the requester that was granted.
module cmd_arbiter
    import cmd_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                       iClock_host,
    input  logic                       iReset,
    input  logic [NUM_REQ-1:0]         iReq,
    input  logic [6*NUM_REQ-1:0]       iReq_index,
    input  logic [32*NUM_REQ-1:0]      iReq_argument,
    output logic [NUM_REQ-1:0]         oGrant,
    output logic [NUM_REQ-1:0]         oDone,
    output logic [CMD_RSP_W-1:0]       oResponse,
    output logic                       oRsp_timeout,
    output logic                       oRsp_index_error,
    output logic                       oNew_command,
    output logic [CMD_INDEX_W-1:0]     oCmd_index,
    output logic [CMD_ARG_W-1:0]       oCmd_argument,
    output logic                       oTimeout_enable,
    output logic                       oTimeout,
    input  logic                       iIdle_out,
    input  logic                       iCommand_complete,
    input  logic                       iCommand_index_error,
    input  logic [CMD_RSP_W-1:0]       iResponse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]       done_q, done_d;
    logic [CMD_RSP_W-1:0]     rsp_q, rsp_d;
    logic                     rsp_to_q, rsp_to_d;
    logic                     rsp_ie_q, rsp_ie_d;
    logic                     new_cmd_q, new_cmd_d;
    logic [CMD_INDEX_W-1:0]   idx_q, idx_d;
    logic [CMD_ARG_W-1:0]     arg_q, arg_d;
    logic                     ten_q, ten_d;
    logic                     to_q, to_d;

    logic [NUM_REQ-1:0]       winner_s;
    logic [CMD_INDEX_W-1:0]   sel_idx_s;
    logic [CMD_ARG_W-1:0]     sel_arg_s;
    logic                     advance_s;

    // The pointer advances during the single DONE cycle.
    assign advance_s = (state_q == ST_DONE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk_i     (iClock_host),
        .rst_i     (iReset),
        .req_i     (iReq),
        .advance_i (advance_s),
        .grant_i   (grant_q),
        .winner_o  (winner_s)
    );

    // Mux the winning requester's index and argument. The winner is one-hot, so OR-reduce.
    always_comb begin
        sel_idx_s = {CMD_INDEX_W{1'b0}};
        sel_arg_s = {CMD_ARG_W{1'b0}};
        for (int r = 0; r < NUM_REQ; r++) begin
            if (winner_s[r]) begin
                sel_idx_s = sel_idx_s | iReq_index[r*CMD_INDEX_W +: CMD_INDEX_W];
                sel_arg_s = sel_arg_s | iReq_argument[r*CMD_ARG_W +: CMD_ARG_W];
            end else begin
                sel_idx_s = sel_idx_s;
                sel_arg_s = sel_arg_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge iClock_host or posedge iReset) begin
        if (iReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. In WAIT, a completion takes priority over expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((|iReq) && iIdle_out) state_d = ST_ISSUE;
                else                      state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (!iIdle_out) state_d = ST_WAIT;
                else            state_d = ST_ISSUE;
            end
            ST_WAIT: begin
                if (iCommand_complete)      state_d = ST_DONE;
                else if (cnt_q == CNT_LAST) state_d = ST_ABORT;
                else                        state_d = ST_WAIT;
            end
            ST_ABORT: begin
                if (iIdle_out) state_d = ST_DONE;
                else           state_d = ST_ABORT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values. All outputs are registered from these.
    always_comb begin
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        arg_d     = arg_q;
        rsp_d     = rsp_q;
        rsp_to_d  = rsp_to_q;
        rsp_ie_d  = rsp_ie_q;

        // Latch the winner and its command fields only when a grant is issued.
        if ((state_q == ST_IDLE) && (state_d == ST_ISSUE)) begin
            grant_d = winner_s;
            idx_d   = sel_idx_s;
            arg_d   = sel_arg_s;
        end else if (state_q == ST_DONE) begin
            grant_d = {NUM_REQ{1'b0}};
        end else begin
            grant_d = grant_q;
        end

        // Timeout counter: cleared while issuing, counts while waiting.
        if (state_q == ST_ISSUE) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Capture the response on completion, or force it to zero after an abort.
        if ((state_q == ST_WAIT) && iCommand_complete) begin
            rsp_d    = iResponse;
            rsp_to_d = 1'b0;
            rsp_ie_d = iCommand_index_error;
        end else if ((state_q == ST_ABORT) && iIdle_out) begin
            rsp_d    = {CMD_RSP_W{1'b0}};
            rsp_to_d = 1'b1;
            rsp_ie_d = 1'b0;
        end else begin
            rsp_d    = rsp_q;
            rsp_to_d = rsp_to_q;
            rsp_ie_d = rsp_ie_q;
        end

        // new_command starts one cycle into ISSUE, giving the two-cycle request
        // latency, and drops as WAIT is entered.
        new_cmd_d = (state_q == ST_ISSUE) && (state_d == ST_ISSUE);
        ten_d     = (state_d != ST_IDLE);
        to_d      = (state_d == ST_ABORT);
        done_d    = (state_d == ST_DONE) ? grant_q : {NUM_REQ{1'b0}};
    end

    // Datapath and output registers.
    always_ff @(posedge iClock_host or posedge iReset) begin
        if (iReset) begin
            cnt_q     <= {CNT_W{1'b0}};
            grant_q   <= {NUM_REQ{1'b0}};
            done_q    <= {NUM_REQ{1'b0}};
            rsp_q     <= {CMD_RSP_W{1'b0}};
            rsp_to_q  <= 1'b0;
            rsp_ie_q  <= 1'b0;
            new_cmd_q <= 1'b0;
            idx_q     <= {CMD_INDEX_W{1'b0}};
            arg_q     <= {CMD_ARG_W{1'b0}};
            ten_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            rsp_q     <= rsp_d;
            rsp_to_q  <= rsp_to_d;
            rsp_ie_q  <= rsp_ie_d;
            new_cmd_q <= new_cmd_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
            ten_q     <= ten_d;
            to_q      <= to_d;
        end
    end

    assign oGrant           = grant_q;
    assign oDone            = done_q;
    assign oResponse        = rsp_q;
    assign oRsp_timeout     = rsp_to_q;
    assign oRsp_index_error = rsp_ie_q;
    assign oNew_command     = new_cmd_q;
    assign oCmd_index       = idx_q;
    assign oCmd_argument    = arg_q;
    assign oTimeout_enable  = ten_q;
    assign oTimeout         = to_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter. The bench itself plays the part of cmd_control
// through iIdle_out, iCommand_complete and iResponse.
module tb_cmd_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [11:0]  req_index;
    logic [63:0]  req_arg;
    logic [1:0]   grant;
    logic [1:0]   done;
    logic [47:0]  rsp;
    logic         rsp_to;
    logic         rsp_ie;
    logic         new_cmd;
    logic [5:0]   cmd_idx;
    logic [31:0]  cmd_arg;
    logic         to_en;
    logic         to;
    logic         idle;
    logic         cmpl;
    logic         ierr;
    logic [47:0]  rsp_in;

    int vectors     = 0;
    int miscompares = 0;

    cmd_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .iClock_host          (clk),
        .iReset               (rst),
        .iReq                 (req),
        .iReq_index           (req_index),
        .iReq_argument        (req_arg),
        .oGrant               (grant),
        .oDone                (done),
        .oResponse            (rsp),
        .oRsp_timeout         (rsp_to),
        .oRsp_index_error     (rsp_ie),
        .oNew_command         (new_cmd),
        .oCmd_index           (cmd_idx),
        .oCmd_argument        (cmd_arg),
        .oTimeout_enable      (to_en),
        .oTimeout             (to),
        .iIdle_out            (idle),
        .iCommand_complete    (cmpl),
        .iCommand_index_error (ierr),
        .iResponse            (rsp_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serve one command from IDLE with a fast completion and check the handshake.
    task automatic serve(input logic [1:0] exp_g, input logic [5:0] exp_idx,
                         input logic [31:0] exp_arg, input logic [47:0] r, input logic e);
        tick;
        chk("grant", {62'd0, grant}, {62'd0, exp_g});
        chk("grant_onehot", {63'd0, ($countones(grant) <= 1)}, 64'd1);
        chk("cmd_index", {58'd0, cmd_idx}, {58'd0, exp_idx});
        chk("cmd_arg", {32'd0, cmd_arg}, {32'd0, exp_arg});
        tick;
        chk("new_cmd", {63'd0, new_cmd}, 64'd1);
        idle = 1'b0;
        tick;
        chk("new_cmd_drop", {63'd0, new_cmd}, 64'd0);
        cmpl = 1'b1; rsp_in = r; ierr = e;
        tick;
        chk("done", {62'd0, done}, {62'd0, exp_g});
        chk("response", {16'd0, rsp}, {16'd0, r});
        chk("rsp_index_error", {63'd0, rsp_ie}, {63'd0, e});
        chk("rsp_timeout", {63'd0, rsp_to}, 64'd0);
        cmpl = 1'b0; ierr = 1'b0; idle = 1'b1;
        tick;
        chk("done_clear", {62'd0, done}, 64'd0);
        chk("grant_clear", {62'd0, grant}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; req_index = 12'd0; req_arg = 64'd0;
        idle = 1'b1; cmpl = 1'b0; ierr = 1'b0; rsp_in = 48'd0;
        tick; tick;
        // Reset state.
        chk("rst_grant", {62'd0, grant}, 64'd0);
        chk("rst_done", {62'd0, done}, 64'd0);
        chk("rst_newcmd", {63'd0, new_cmd}, 64'd0);
        chk("rst_to_en", {63'd0, to_en}, 64'd0);
        chk("rst_timeout", {63'd0, to}, 64'd0);
        chk("rst_response", {16'd0, rsp}, 64'd0);
        rst = 1'b0;
        tick;

        // Both requesters held: alternating grants starting at requester 0.
        req_index = {6'h02, 6'h01};
        req_arg   = {32'h0000_00B0, 32'h0000_00A0};
        req = 2'b11;
        serve(2'b01, 6'h01, 32'h0000_00A0, 48'h0000_0000_0A01, 1'b0);
        serve(2'b10, 6'h02, 32'h0000_00B0, 48'h0000_0000_0B01, 1'b0);
        serve(2'b01, 6'h01, 32'h0000_00A0, 48'h0000_0000_0A02, 1'b0);
        serve(2'b10, 6'h02, 32'h0000_00B0, 48'h0000_0000_0B02, 1'b0);
        req = 2'b00;
        tick;

        // Single request from requester 0: latency, a 10-cycle completion, and the response.
        req_index = {6'h00, 6'h11};
        req_arg   = {32'd0, 32'd5};
        req = 2'b01;
        tick;
        chk("t1_grant", {62'd0, grant}, 64'd1);
        chk("t1_newcmd_early", {63'd0, new_cmd}, 64'd0);
        chk("t1_to_en", {63'd0, to_en}, 64'd1);
        chk("t1_index", {58'd0, cmd_idx}, 64'h11);
        tick;
        chk("t1_newcmd", {63'd0, new_cmd}, 64'd1);
        chk("t1_arg", {32'd0, cmd_arg}, 64'd5);
        idle = 1'b0;
        tick;
        chk("t1_newcmd_drop", {63'd0, new_cmd}, 64'd0);
        repeat (9) tick;
        chk("t1_no_done_yet", {62'd0, done}, 64'd0);
        cmpl = 1'b1; rsp_in = 48'h1234_5678_9ABC;
        tick;
        chk("t1_done", {62'd0, done}, 64'd1);
        chk("t1_response", {16'd0, rsp}, 64'h1234_5678_9ABC);
        chk("t1_rsp_to", {63'd0, rsp_to}, 64'd0);
        chk("t1_rsp_ie", {63'd0, rsp_ie}, 64'd0);
        cmpl = 1'b0; idle = 1'b1; req = 2'b00;
        tick;
        chk("t1_done_pulse", {62'd0, done}, 64'd0);
        chk("t1_to_en_clear", {63'd0, to_en}, 64'd0);

        // Requester 1 alone (pointer now at 1) with an index error on completion.
        req_index = {6'h2A, 6'h00};
        req_arg   = {32'hCAFE_0001, 32'd0};
        req = 2'b10;
        serve(2'b10, 6'h2A, 32'hCAFE_0001, 48'hFFFF_FFFF_FFFF, 1'b1);
        req = 2'b00;

        // Controller busy while IDLE: no grant is issued.
        idle = 1'b0; req = 2'b01; req_index = {6'h00, 6'h05}; req_arg = {32'd0, 32'd7};
        tick; tick;
        chk("busy_no_grant", {62'd0, grant}, 64'd0);
        chk("busy_no_newcmd", {63'd0, new_cmd}, 64'd0);
        idle = 1'b1;

        // Timeout: no completion arrives.
        tick;
        chk("t3_grant", {62'd0, grant}, 64'd1);
        tick;
        idle = 1'b0; rsp_in = 48'hDEAD_BEEF_0000;
        tick;
        repeat (63) tick;
        chk("t3_timeout_not_yet", {63'd0, to}, 64'd0);
        tick;
        chk("t3_timeout_rise", {63'd0, to}, 64'd1);
        repeat (3) tick;
        chk("t3_timeout_held", {63'd0, to}, 64'd1);
        chk("t3_no_done", {62'd0, done}, 64'd0);
        idle = 1'b1;
        tick;
        chk("t3_timeout_fall", {63'd0, to}, 64'd0);
        chk("t3_done", {62'd0, done}, 64'd1);
        chk("t3_rsp_to", {63'd0, rsp_to}, 64'd1);
        chk("t3_response_zero", {16'd0, rsp}, 64'd0);
        req = 2'b00;
        tick;

        // Completion on the exact expiry cycle: the completion wins.
        req = 2'b01;
        tick; tick;
        idle = 1'b0;
        tick;
        repeat (62) tick;
        chk("t5_timeout_low", {63'd0, to}, 64'd0);
        tick;
        cmpl = 1'b1; rsp_in = 48'h0000_5555_AAAA;
        tick;
        chk("t5_done", {62'd0, done}, 64'd1);
        chk("t5_no_timeout", {63'd0, to}, 64'd0);
        chk("t5_rsp_to", {63'd0, rsp_to}, 64'd0);
        chk("t5_response", {16'd0, rsp}, 64'h0000_5555_AAAA);
        cmpl = 1'b0; idle = 1'b1; req = 2'b00;
        tick;

        // Asynchronous reset in the middle of WAIT.
        req = 2'b01;
        tick; tick;
        idle = 1'b0;
        tick; tick; tick;
        rst = 1'b1;
        #1;
        chk("t6_grant_zero", {62'd0, grant}, 64'd0);
        chk("t6_to_en_zero", {63'd0, to_en}, 64'd0);
        chk("t6_index_zero", {58'd0, cmd_idx}, 64'd0);
        chk("t6_done_zero", {62'd0, done}, 64'd0);
        tick;
        rst = 1'b0; idle = 1'b1;
        chk("t6_no_done", {62'd0, done}, 64'd0);
        // After reset the pointer restarts at 0, so requester 0 wins over requester 1.
        req_index = {6'h3F, 6'h05};
        req_arg   = {32'hFFFF_0000, 32'h0000_0007};
        req = 2'b11;
        serve(2'b01, 6'h05, 32'h0000_0007, 48'h0000_0000_0707, 1'b0);
        req = 2'b00;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
